// File: rtl/controle_trava.sv
// Lock controller fed by the serial-password checker: opens the door for a fixed
// time on a correct code and enters a timed lockout after repeated wrong codes.
module controle_trava #(
    parameter int ABRE_CICLOS = 8,
    parameter int MAX_ERROS   = 3,
    parameter int BLOQ_CICLOS = 16,
    parameter int CNT_W       = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             aberta,
    input  logic                             erro,
    input  logic                             fechar,
    output logic                             porta,
    output logic                             bloqueado,
    output logic                             alarme,
    output logic                             habilita_entrada,
    output logic [$clog2(MAX_ERROS+1)-1:0]   erros
);

    localparam int ERR_W = $clog2(MAX_ERROS + 1);

    localparam logic [CNT_W-1:0] ABRE_INI  = CNT_W'(ABRE_CICLOS - 1);
    localparam logic [CNT_W-1:0] BLOQ_INI  = CNT_W'(BLOQ_CICLOS - 1);
    localparam logic [CNT_W-1:0] TIMER_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] TIMER_UM   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERROS_ZERO = {ERR_W{1'b0}};
    localparam logic [ERR_W:0]   ERROS_UM   = {{ERR_W{1'b0}}, 1'b1};
    localparam logic [ERR_W:0]   MAX_ERR    = (ERR_W + 1)'(MAX_ERROS);

    typedef enum logic [1:0] {
        FECHADA  = 2'b00,
        ABERTA   = 2'b01,
        BLOQUEIO = 2'b10
    } estado_t;

    // Even parity over the state register; a flipped state bit is caught
    // even when it lands on another legal encoding.
    function automatic logic paridade_estado(input logic [1:0] e);
        return ^e;
    endfunction

    estado_t          estado_r;
    estado_t          estado_s;
    logic             par_r;
    logic [CNT_W-1:0] timer_r;
    logic [CNT_W-1:0] timer_s;
    logic [ERR_W-1:0] erros_r;
    logic [ERR_W-1:0] erros_s;
    logic [ERR_W:0]   erros_inc_s;
    logic             alarme_s;
    logic             porta_r;
    logic             bloqueado_r;
    logic             alarme_r;
    logic             habilita_r;

    assign erros_inc_s = {1'b0, erros_r} + ERROS_UM;

    // Next-state, timer and error-count logic.
    always_comb begin
        estado_s = estado_r;
        timer_s  = timer_r;
        erros_s  = erros_r;
        alarme_s = 1'b0;
        if (paridade_estado(estado_r) != par_r) begin
            estado_s = FECHADA;
            timer_s  = TIMER_ZERO;
            erros_s  = ERROS_ZERO;
        end else begin
            case (estado_r)
                FECHADA: begin
                    // erro wins over aberta when both arrive together
                    if (erro) begin
                        if (erros_inc_s >= MAX_ERR) begin
                            estado_s = BLOQUEIO;
                            timer_s  = BLOQ_INI;
                            erros_s  = ERROS_ZERO;
                            alarme_s = 1'b1;
                        end else begin
                            erros_s = erros_inc_s[ERR_W-1:0];
                        end
                    end else if (aberta) begin
                        estado_s = ABERTA;
                        timer_s  = ABRE_INI;
                        erros_s  = ERROS_ZERO;
                    end else begin
                        estado_s = FECHADA;
                    end
                end
                ABERTA: begin
                    if (fechar) begin
                        estado_s = FECHADA;
                        timer_s  = TIMER_ZERO;
                    end else if (timer_r == TIMER_ZERO) begin
                        estado_s = FECHADA;
                    end else begin
                        timer_s = timer_r - TIMER_UM;
                    end
                end
                BLOQUEIO: begin
                    if (timer_r == TIMER_ZERO) begin
                        estado_s = FECHADA;
                        erros_s  = ERROS_ZERO;
                    end else begin
                        timer_s = timer_r - TIMER_UM;
                    end
                end
                default: begin
                    estado_s = FECHADA;
                    timer_s  = TIMER_ZERO;
                    erros_s  = ERROS_ZERO;
                end
            endcase
        end
    end

    // State, counters and outputs, all derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_r    <= FECHADA;
            par_r       <= 1'b0;
            timer_r     <= TIMER_ZERO;
            erros_r     <= ERROS_ZERO;
            porta_r     <= 1'b0;
            bloqueado_r <= 1'b0;
            alarme_r    <= 1'b0;
            habilita_r  <= 1'b1;
        end else begin
            estado_r    <= estado_s;
            par_r       <= paridade_estado(estado_s);
            timer_r     <= timer_s;
            erros_r     <= erros_s;
            porta_r     <= (estado_s == ABERTA);
            bloqueado_r <= (estado_s == BLOQUEIO);
            alarme_r    <= alarme_s;
            habilita_r  <= (estado_s == FECHADA);
        end
    end

    assign porta            = porta_r;
    assign bloqueado        = bloqueado_r;
    assign alarme           = alarme_r;
    assign habilita_entrada = habilita_r;
    assign erros            = erros_r;

endmodule
